// File: rtl/counter_arbiter_if.sv
// Bundles the requester-side handshake of the shared counter arbiter.
// No logic of its own; latency is whatever the arbiter adds (1 cycle, registered).
// No backpressure: requesters hold req for the whole window, the arbiter answers with gnt/done.
`timescale 1ns/1ps
interface counter_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 4
);
    logic [NUM_REQ-1:0] req;
    logic [CNT_W-1:0]   term_val;
    logic [NUM_REQ-1:0] gnt;
    logic [CNT_W-1:0]   count;
    logic [NUM_REQ-1:0] done;
    logic               busy;

    // Requester side: drives the level requests and the terminal count
    modport master (
        output req,
        output term_val,
        input  gnt,
        input  count,
        input  done,
        input  busy
    );

    // Arbiter side
    modport slave (
        input  req,
        input  term_val,
        output gnt,
        output count,
        output done,
        output busy
    );
endinterface

// File: rtl/counter_arbiter.sv
// Round-robin arbiter sharing one up-counter; the winner owns it for a 0..term_val window.
// Latency: grant appears 1 cycle after req is seen in IDLE; all outputs registered.
// Backpressure: dropping the owner's req aborts the window; other requesters wait their turn.
`timescale 1ns/1ps
module counter_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    counter_arbiter_if.slave  bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   ptr, ptr_nxt;
    logic [PTR_W-1:0]   owner, owner_nxt;
    logic [CNT_W-1:0]   term_lat, term_lat_nxt;
    logic [CNT_W-1:0]   count, count_nxt;
    logic [NUM_REQ-1:0] gnt, gnt_nxt;
    logic [NUM_REQ-1:0] done, done_nxt;
    logic               busy, busy_nxt;

    logic [PTR_W-1:0]   cand;
    logic [PTR_W-1:0]   pick;
    logic               pick_vld;

    // Search requesters starting just after the last served one, wrapping around
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (!pick_vld && bus.req[cand]) begin
                pick_vld = 1'b1;
                pick     = cand;
            end
        end
    end

    // Next-state and next-output logic; abort takes precedence over completion
    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        owner_nxt    = owner;
        term_lat_nxt = term_lat;
        count_nxt    = '0;
        gnt_nxt      = '0;
        done_nxt     = '0;
        unique case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt    = RUN;
                    owner_nxt    = pick;
                    term_lat_nxt = bus.term_val;
                    gnt_nxt      = NUM_REQ'(1) << pick;
                end
            end
            RUN: begin
                if (!bus.req[owner]) begin
                    state_nxt = IDLE;
                    ptr_nxt   = owner;
                end else if (count == term_lat) begin
                    state_nxt = DONE;
                    done_nxt  = NUM_REQ'(1) << owner;
                    ptr_nxt   = owner;
                end else begin
                    count_nxt = count + CNT_W'(1);
                    gnt_nxt   = gnt;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    // State and registered outputs; reset is honoured immediately, even mid-window
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= PTR_W'(NUM_REQ - 1);
            owner    <= '0;
            term_lat <= '0;
            count    <= '0;
            gnt      <= '0;
            done     <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            owner    <= owner_nxt;
            term_lat <= term_lat_nxt;
            count    <= count_nxt;
            gnt      <= gnt_nxt;
            done     <= done_nxt;
            busy     <= busy_nxt;
        end
    end

    assign bus.gnt   = gnt;
    assign bus.count = count;
    assign bus.done  = done;
    assign bus.busy  = busy;

endmodule
